// File: rtl/gen_linear_part_seq.sv
// rtl/gen_linear_part_seq.sv - sequential XOR rebuild of CLA carries from the non-linear product vector
//
// Purpose:
//   Consumes the non-linear product-term vector of a decomposed carry-lookahead
//   adder. It rebuilds one carry per clock by XOR-reducing one term block, and
//   forms the sum bit for that position. The result is presented with a
//   valid/ready handshake.
//
// Parameters:
//   NBIT   adder width
//   NNL    width of the non-linear vector (derived, 2**(NBIT+2)-NBIT-4)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   a, b, c, n valid
//   in_ready   out  block can accept an operand set (IDLE and not in reset)
//   a, b       in   adder operands, NBIT bits
//   c          in   carry in
//   n          in   non-linear product terms, NNL bits, generator order
//   out_valid  out  s and cout valid (DONE)
//   out_ready  in   downstream accepts the result
//   s          out  sum, NBIT bits
//   cout       out  carry out
//   err        out  self-check mismatch (only with GEN_LINEAR_PART_SELFCHECK_EN)
//
// Optional feature macro: GEN_LINEAR_PART_SELFCHECK_EN
//   When defined, a reference sum a+b+c is captured with the operands. err
//   flags a disagreement with {cout,s} while the result is valid.

module gen_linear_part_seq #(
    parameter  int NBIT = 7,
    localparam int NNL  = (1 << (NBIT + 2)) - NBIT - 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c,
    input  logic [NNL-1:0]  n,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] s,
    output logic            cout
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
    ,
    output logic            err
`endif
);

    // j counts up to NBIT after the last RUN cycle, so it needs room for NBIT.
    localparam int JW = $clog2(NBIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NBIT-1:0] a_q, a_d;
    logic [NBIT-1:0] b_q, b_d;
    logic [NNL-1:0]  n_q, n_d;
    logic [NBIT-1:0] s_q, s_d;
    logic            carry_q, carry_d;
    logic [JW-1:0]   j_q, j_d;

    // Parity of each term block of the captured vector. Offsets and lengths
    // are elaboration constants; at run time only the block select moves.
    logic [NBIT-1:0] blk_par;

    for (genvar g = 0; g < NBIT; g++) begin : g_blk
        localparam int OFF = (1 << (g + 2)) - 4 - g;
        localparam int LEN = (1 << (g + 2)) - 1;
        assign blk_par[g] = ^n_q[OFF +: LEN];
    end

`ifdef GEN_LINEAR_PART_SELFCHECK_EN
    logic [NBIT:0] ref_q, ref_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        n_d       = n_q;
        s_d       = s_q;
        carry_d   = carry_q;
        j_d       = j_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        s         = '0;
        cout      = 1'b0;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
        ref_d     = ref_q;
        err       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // The reset term keeps in_ready low during any reset cycle.
                in_ready = ~rst;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    carry_d = c;
                    s_d     = '0;
                    j_d     = '0;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
                    ref_d   = {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, c};
`endif
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // carry_q holds carry[j]; block j reduces to carry[j+1].
                s_d[j_q] = a_q[j_q] ^ b_q[j_q] ^ carry_q;
                carry_d  = blk_par[j_q];
                j_d      = j_q + 1'b1;
                if (j_q == JW'(NBIT - 1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                s         = s_q;
                cout      = carry_q;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
                err       = ({carry_q, s_q} != ref_q);
`endif
                // in_valid is not looked at here; a new operand waits for IDLE.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            j_q     <= '0;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
            ref_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            j_q     <= j_d;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
            ref_q   <= ref_d;
`endif
        end
    end

endmodule

// File: tb/tb_gen_linear_part_seq.sv
// tb/tb_gen_linear_part_seq.sv - directed scoreboard bench for gen_linear_part_seq

module tb_gen_linear_part_seq;

    localparam int NBIT = 7;
    localparam int NNL  = (1 << (NBIT + 2)) - NBIT - 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            c;
    logic [NNL-1:0]  n;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] s;
    logic            cout;
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
    logic            err;
`endif

    gen_linear_part_seq #(.NBIT(NBIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
        ,
        .err       (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [NBIT:0] sb_q[$];
    int            acc_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Product-vector model: block j holds the CLA product terms of carry[j+1]
    // (g_j, p_j g_(j-1), ..., p_j..p_0 c), which are mutually exclusive and so
    // XOR to the carry, followed by random filler whose parity cancels.
    function automatic logic [NNL-1:0] gen_n(input logic [NBIT-1:0] av,
                                             input logic [NBIT-1:0] bv,
                                             input logic cv);
        logic [NNL-1:0]  v;
        logic [NBIT-1:0] p;
        logic [NBIT-1:0] g;
        logic            t;
        logic            par;
        logic            r;
        int              base;
        int              len;
        int              idx;
        v = '0;
        p = av ^ bv;
        g = av & bv;
        for (int j = 0; j < NBIT; j++) begin
            base = (1 << (j + 2)) - 4 - j;
            len  = (1 << (j + 2)) - 1;
            idx  = 0;
            for (int k = 0; k <= j; k++) begin
                t = g[j-k];
                for (int m = j - k + 1; m <= j; m++) t &= p[m];
                v[base+idx] = t;
                idx++;
            end
            t = cv;
            for (int m = 0; m <= j; m++) t &= p[m];
            v[base+idx] = t;
            idx++;
            par = 1'b0;
            while (idx < len - 1) begin
                r = 1'($urandom);
                v[base+idx] = r;
                par ^= r;
                idx++;
            end
            v[base+len-1] = par;
        end
        return v;
    endfunction

    function automatic logic [NBIT:0] ref_sum(input logic [NBIT-1:0] av,
                                              input logic [NBIT-1:0] bv,
                                              input logic cv);
        return {1'b0, av} + {1'b0, bv} + {{NBIT{1'b0}}, cv};
    endfunction

    task automatic set_op(input logic [NBIT-1:0] av, input logic [NBIT-1:0] bv,
                          input logic cv, input bit corrupt);
        a = av;
        b = bv;
        c = cv;
        n = gen_n(av, bv, cv);
        if (corrupt) n[0] = 1'b0;
    endtask

    // Offer the current operands; push the expected result on acceptance.
    task automatic accept(input string tag, input logic [NBIT:0] exp, input bit hold);
        int waited;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            sb_q.push_back(exp);
            tick();
            if (!hold) in_valid = 1'b0;
        end
    endtask

    // Called in the cycle after acceptance; returns cycles since acceptance.
    task automatic wait_out(output int lat, output int rdy_hi);
        lat = 1;
        rdy_hi = 0;
        while (!out_valid && lat < 30) begin
            if (in_ready) rdy_hi++;
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag);
        logic [NBIT:0] exp;
        out_ready = 1'b1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_result"}, 32'({cout, s}), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rdy;
        int first_acc;
        int ov_cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        c = 1'b0;
        n = '0;

        // Reset state
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_s", 32'(s), 32'd0);
        chk("post_rst_cout", 32'(cout), 32'd0);
`ifdef GEN_LINEAR_PART_SELFCHECK_EN
        chk("post_rst_err", 32'(err), 32'd0);
`endif

        // 1: 0x7F + 0x01, latency
        set_op(7'h7F, 7'h01, 1'b0, 1'b0);
        accept("t1", ref_sum(7'h7F, 7'h01, 1'b0), 1'b0);
        chk("t1_exp_const", 32'(ref_sum(7'h7F, 7'h01, 1'b0)), 32'h80);
        wait_out(lat, rdy);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_busy_in_ready", 32'(rdy), 32'd0);
        check_result("t1");
        tick();
        chk("t1_retired", 32'(out_valid), 32'd0);
        chk("t1_idle_ready", 32'(in_ready), 32'd1);

        // 2: back-to-back with out_ready held high
        out_ready = 1'b1;
        set_op(7'h55, 7'h2A, 1'b1, 1'b0);
        accept("t2a", 8'h80, 1'b0);
        first_acc = acc_cyc;
        wait_out(lat, rdy);
        chk("t2a_latency", 32'(lat), 32'd8);
        check_result("t2a");
        tick();
        set_op(7'h12, 7'h34, 1'b0, 1'b0);
        accept("t2b", 8'h46, 1'b0);
        chk("t2_accept_spacing", 32'(acc_cyc - first_acc), 32'd9);
        wait_out(lat, rdy);
        check_result("t2b");
        tick();

        // 3: backpressure
        out_ready = 1'b0;
        set_op(7'h03, 7'h05, 1'b0, 1'b0);
        accept("t3", 8'h08, 1'b0);
        wait_out(lat, rdy);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_s", 32'(s), 32'h08);
            chk("t3_hold_cout", 32'(cout), 32'd0);
            chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check_result("t3");
        tick();
        chk("t3_retired", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // 4: reset in the third RUN cycle discards the operation
        set_op(7'h2C, 7'h19, 1'b1, 1'b0);
        accept("t4", ref_sum(7'h2C, 7'h19, 1'b1), 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t4_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_s", 32'(s), 32'd0);
        chk("t4_cout", 32'(cout), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        void'(sb_q.pop_back());
        out_ready = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) ov_cnt++;
            tick();
        end
        chk("t4_no_result", 32'(ov_cnt), 32'd0);
        out_ready = 1'b0;

        // 5: in_valid held high while busy, operands change after accept
        set_op(7'h7F, 7'h7F, 1'b1, 1'b0);
        accept("t5", 8'hFF, 1'b1);
        set_op(7'h11, 7'h22, 1'b0, 1'b0);
        wait_out(lat, rdy);
        chk("t5_latency", 32'(lat), 32'd8);
        chk("t5_busy_in_ready", 32'(rdy), 32'd0);
        check_result("t5");
        tick();
        chk("t5_retired", 32'(out_valid), 32'd0);
        chk("t5_idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) ov_cnt++;
            tick();
        end
        chk("t5_no_second", 32'(ov_cnt), 32'd0);
        out_ready = 1'b0;

`ifdef GEN_LINEAR_PART_SELFCHECK_EN
        // 6: self-check with corrupted and clean product vectors
        set_op(7'h01, 7'h01, 1'b0, 1'b1);
        accept("t6a", 8'h00, 1'b0);
        wait_out(lat, rdy);
        chk("t6a_err", 32'(err), 32'd1);
        check_result("t6a");
        tick();
        chk("t6a_err_cleared", 32'(err), 32'd0);
        set_op(7'h01, 7'h01, 1'b0, 1'b0);
        accept("t6b", 8'h02, 1'b0);
        wait_out(lat, rdy);
        chk("t6b_err", 32'(err), 32'd0);
        check_result("t6b");
        tick();
        out_ready = 1'b0;
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gen_linear_part_seq.md
Name: gen_linear_part_seq

Overview:
- Sequential consumer of the non-linear product vector of the decomposed CLA adder.
- XOR-combines the product terms block by block, one input bit per clock, to rebuild the carries.
- Produces sum bits s = a ^ b ^ carry and carry-out.
- Sits downstream of the non-linear generator; valid/ready handshakes on both sides.

Parameters:
- NBIT, 7: adder width. Taken from constants.v.
- NNL, 2**(NBIT+2)-NBIT-4: width of the non-linear vector. Derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- in_valid  in  1  a, b, c, n valid.
- in_ready  out  1  block can accept an operand set.
- a  in  NBIT  adder operand.
- b  in  NBIT  adder operand.
- c  in  1  carry in.
- n  in  NNL  non-linear product terms, in generator order.
- out_valid  out  1  s and cout valid.
- out_ready  in  1  downstream accepts the result.
- s  out  NBIT  sum.
- cout  out  1  carry out.
- err  out  1  self-check mismatch. Present only with the optional feature.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk/rst.
- Term layout of n: block j, for j = 0..NBIT-1, holds 2**(j+2)-1 terms.
  - Offset of block j: off_j = 2**(j+2)-4-j.
  - Block j occupies n[off_j +: 2**(j+2)-1].
  - carry[0] = c.
  - carry[j+1] = XOR reduction of block j.
  - s[j] = a[j] ^ b[j] ^ carry[j].
  - cout = carry[NBIT].
- Block masks/offsets are elaborated constants. No runtime arithmetic on offsets.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: register a, b, n; carry_r <= c; j <= 0; go to RUN.
  - RUN:
    - in_ready = 0.
    - Each cycle: s_r[j] <= a_r[j] ^ b_r[j] ^ carry_r; carry_r <= ^(n_r & mask_j); j <= j+1.
    - After the cycle with j == NBIT-1: go to DONE.
  - DONE:
    - out_valid = 1. cout = carry_r.
    - s and cout are held stable while out_ready = 0.
    - On out_ready: go to IDLE. in_ready rises the next cycle.
- Latency:
  - out_valid rises NBIT+1 cycles after the accepting cycle.
  - Throughput is one result per NBIT+2 cycles when out_ready is held high.
- Inputs are ignored outside IDLE. No queueing.
- Reset values: state IDLE; out_valid 0; s 0; cout 0; err 0; j 0; carry_r 0.
- in_ready is 0 in any cycle where rst = 1.
- Reset mid-RUN or mid-DONE discards the operation. No partial result is ever presented.
- j is sized ceil(log2(NBIT+1)). It never wraps past NBIT-1.
- Simultaneous out_ready and in_valid in DONE: the result is retired, and the new operand is not accepted until the next IDLE cycle.

Optional Feature:
- Macro: GEN_LINEAR_PART_SELFCHECK_EN.
- When defined:
  - On the capture cycle, also register the reference sum {a}+{b}+c, NBIT+1 bits.
  - In DONE, err = ({cout,s} != reference). err is valid with out_valid and is cleared on leaving DONE.
  - err does not alter the data path or the handshake.
- When undefined: no err port and no reference adder.

Test Plan (NBIT=7, n produced by the non-linear generator from the same a, b, c):
- a=0x7F, b=0x01, c=0 -> s=0x00, cout=1. out_valid high exactly 8 cycles after acceptance.
- a=0x55, b=0x2A, c=1 -> s=0x00, cout=1. Then a=0x12, b=0x34, c=0 -> s=0x46, cout=0. out_ready held high; second accept 9 cycles after the first.
- Backpressure: a=0x03, b=0x05, c=0, out_ready low for 5 cycles in DONE -> s=0x08 and cout=0 stable throughout, in_ready=0 throughout. Retired on the first out_ready cycle.
- Reset: assert rst for one cycle in the 3rd RUN cycle -> next cycle state IDLE, out_valid=0, s=0, cout=0. in_ready=1 one cycle after rst deasserts; no result emitted.
- In_valid held high while busy (a=0x7F, b=0x7F, c=1 first) -> only the first is accepted. s=0x7F, cout=1.
- SELFCHECK_EN: a=0x01, b=0x01, c=0 with n[0] forced to 0 -> s=0x00, cout=0, err=1. With n uncorrupted -> s=0x02, err=0.
